// File: rtl/reg_ascii_streamer.sv
// Round-robin binary-to-ASCII decimal streamer. Each grant runs a double-dabble
// conversion and then sends the digits one character at a time, most significant first.
// Latency: ack follows WIDTH conversion cycles plus DIGITS transfers plus the DONE cycle.
// Backpressure: char_ready low stalls SEND, and char_data/char_last hold steady during the stall.
// Build option LEADING_BLANK_EN: leading zero digits are sent as spaces. The index-0 digit is always a numeral.
// DIGITS must be large enough that 10^DIGITS > 2^WIDTH-1.
module reg_ascii_streamer #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter int NREQ   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     value,
  output logic [7:0]                char_data,
  output logic                      char_valid,
  input  logic                      char_ready,
  output logic                      char_last,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int GW = $clog2(NREQ);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [BW-1:0]   bcd_adj;
  logic            found;
  logic [GW-1:0]   pick;
  logic [3:0]      nib;
  logic            blank;

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  // Round-robin search: find the first pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
  end

  assign nib = bcd_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_BLANK_EN
  // Blank a position when it and every digit above it are zero; index 0 is never blanked.
  assign blank = (idx_q != '0) && ((bcd_q >> {idx_q, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  // Next-state logic and datapath updates for the four-state sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    opnd_d   = opnd_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = CONV;
          gid_d   = pick;
          opnd_d  = value[pick*WIDTH +: WIDTH];
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      CONV: begin
        {bcd_d, opnd_d} = {bcd_adj, opnd_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SEND;
          idx_d   = IW'(DIGITS - 1);
        end
      end
      SEND: begin
        if (char_ready) begin
          if (idx_q == '0) state_d = DONE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      opnd_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      opnd_q   <= opnd_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs are decoded from registered state, so reset clears them at once.
  always_comb begin
    busy       = (state_q != IDLE);
    char_valid = (state_q == SEND);
    char_last  = (state_q == SEND) && (idx_q == '0);
    char_data  = 8'h20;
    if (state_q == SEND) char_data = blank ? 8'h20 : (8'h30 + {4'h0, nib});
    ack        = (state_q == DONE) ? (NREQ'(1) << gid_q) : '0;
    grant_id   = gid_q;
  end

endmodule

// File: tb/tb_reg_ascii_streamer.sv
// Scoreboard bench for reg_ascii_streamer (WIDTH=8, DIGITS=3, NREQ=2).
// Expected characters and grants are queued when requests are driven, then checked as the DUT emits them.
module tb_reg_ascii_streamer;
  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req;
  logic [N*W-1:0]       value;
  logic [7:0]           char_data;
  logic                 char_valid;
  logic                 char_ready;
  logic                 char_last;
  logic [N-1:0]         ack;
  logic                 busy;
  logic [$clog2(N)-1:0] grant_id;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_chars[$];   // {last, data}
  int         exp_ids[$];

  reg_ascii_streamer #(.WIDTH(W), .DIGITS(D), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .value(value),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_last(char_last), .ack(ack), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference digits come from division by 10, which is independent of the DUT's double-dabble.
  function automatic void push_exp(input int id, input logic [7:0] v);
    int         d[3];
    logic [7:0] c;
`ifdef LEADING_BLANK_EN
    bit         nz;
    nz = 1'b0;
`endif
    d[2] = int'(v) / 100;
    d[1] = (int'(v) / 10) % 10;
    d[0] = int'(v) % 10;
    for (int p = 2; p >= 0; p--) begin
      c = 8'h30 + 8'(d[p]);
`ifdef LEADING_BLANK_EN
      if (p != 0 && !nz && d[p] == 0) c = 8'h20;
      if (d[p] != 0) nz = 1'b1;
`endif
      exp_chars.push_back({(p == 0), c});
    end
    exp_ids.push_back(id);
  endfunction

  // Monitor: sample between edges, checking each offered character and each ack against the scoreboard.
  always @(negedge clk) begin
    int id;
    if (!rst) begin
      if (char_valid) begin
        if (exp_chars.size() == 0) begin
          check("char_unexp", char_data, 8'h00);
        end else begin
          check(char_ready ? "char" : "char_hold", char_data, exp_chars[0][7:0]);
          check("last", char_last, exp_chars[0][8]);
          if (char_ready) void'(exp_chars.pop_front());
        end
      end
      if (ack != '0) begin
        if (exp_ids.size() == 0) begin
          check("ack_unexp", ack, 0);
        end else begin
          id = exp_ids.pop_front();
          check("ack", ack, 32'(1) << id);
          check("gid", grant_id, id);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int id, input logic [7:0] v, output int lat);
    value[id*W +: W] = v;
    push_exp(id, v);
    req[id] = 1'b1;
    lat = 0;
    while (ack[id] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("ack_wait", lat < 200, 1);
    req[id] = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((busy || exp_chars.size() != 0 || exp_ids.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("quiet_wait", n < 200, 1);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!char_valid && n < 200) begin
      tick();
      n++;
    end
    check("valid_wait", n < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, acks, n;
    rst = 1'b1; req = '0; value = '0; char_ready = 1'b1;
    #1;
    check("rst_valid", char_valid, 0);
    check("rst_last",  char_last, 0);
    check("rst_data",  char_data, 8'h20);
    check("rst_ack",   ack, 0);
    check("rst_busy",  busy, 0);
    check("rst_gid",   grant_id, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 255 on requester 0, including grant-to-ack latency with char_ready held high.
    serve(0, 8'd255, lat);
    check("latency", lat, W + D + 1);
    wait_quiet();

    // Leading-zero handling on requester 1.
    serve(1, 8'd7, lat);
    wait_quiet();
    serve(1, 8'd0, lat);
    wait_quiet();

    // Round robin from reset. Requester 0 stays high throughout, so it is re-requested right after its ack.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    value = {8'd2, 8'd1};
    push_exp(0, 8'd1);
    push_exp(1, 8'd2);
    push_exp(0, 8'd1);
    req = 2'b11;
    acks = 0; n = 0;
    while (acks < 3 && n < 500) begin
      tick();
      n++;
      if (ack != '0) begin
        acks++;
        if (acks == 2) req[1] = 1'b0;
        if (acks == 3) req[0] = 1'b0;
      end
    end
    check("rr_acks", acks, 3);
    wait_quiet();

    // Backpressure on the second character of 120.
    value[0 +: W] = 8'd120;
    push_exp(0, 8'd120);
    req[0] = 1'b1;
    wait_valid();
    tick();
    char_ready = 1'b0;
    repeat (5) tick();
    char_ready = 1'b1;
    n = 0;
    while (ack[0] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("stall_ack_wait", n < 200, 1);
    req[0] = 1'b0;
    wait_quiet();

    // Reset after one transfer abandons the stream. The next request starts at the first digit.
    value[0 +: W] = 8'd45;
    push_exp(0, 8'd45);
    req[0] = 1'b1;
    wait_valid();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", char_valid, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_ack",   ack, 0);
    check("mid_rst_data",  char_data, 8'h20);
    exp_chars.delete();
    exp_ids.delete();
    req = '0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    serve(0, 8'd45, lat);
    wait_quiet();

    check("sb_chars_left", exp_chars.size(), 0);
    check("sb_acks_left", exp_ids.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_ascii_streamer.md
REG_ASCII_STREAMER -- requirements
Module: reg_ascii_streamer

Interface
REQ-001 Parameter WIDTH, default 32: binary operand width in bits.
REQ-002 Parameter DIGITS, default 10: decimal digit count; SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Parameter NREQ, default 4: number of requesters, minimum 2.
REQ-004 Port clk  in  1: single clock, rising edge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Port req  in  NREQ: level request per requester, held high until its ack.
REQ-007 Port value  in  NREQ*WIDTH: requester i operand at bits [i*WIDTH +: WIDTH], unsigned.
REQ-008 Port char_data  out  8: ASCII character to the display sink.
REQ-009 Port char_valid  out  1: char_data valid.
REQ-010 Port char_ready  in  1: sink accepts; transfer occurs on a cycle with char_valid=1 and char_ready=1.
REQ-011 Port char_last  out  1: high with the final (least significant) digit.
REQ-012 Port ack  out  NREQ: one-hot, single-cycle completion pulse.
REQ-013 Port busy  out  1: high in every state except IDLE.
REQ-014 Port grant_id  out  $clog2(NREQ): index of the requester being served.

Function
REQ-015 FSM states: IDLE, CONV, SEND, DONE.
REQ-016 IDLE: when any req bit is high, grant the first high bit searching upward from rr_ptr with wrap, latch its value and grant_id, clear the BCD register and the iteration counter, then go to CONV.
REQ-017 CONV: exactly WIDTH cycles of double-dabble; each cycle adds 3 to every BCD nibble >= 5, then shifts {BCD, operand} left by one bit; after WIDTH cycles, go to SEND with digit index = DIGITS-1.
REQ-018 SEND: char_valid=1; char_data = 8'h30 + BCD nibble at the current index; each transfer decrements the index; char_last=1 when the index is 0; after the index-0 transfer, go to DONE.
REQ-019 With char_valid=1 and char_ready=0, char_data and char_last SHALL hold stable.
REQ-020 DONE: ack[grant_id]=1 for exactly one cycle; rr_ptr = (grant_id+1) mod NREQ; go to IDLE.
REQ-021 With char_ready held high, ack SHALL assert WIDTH+DIGITS+1 cycles after the granting edge.
REQ-022 req and value changes after the granting edge SHALL be ignored until IDLE is re-entered.
REQ-023 A req bit still high in the first IDLE cycle after DONE SHALL be treated as a new request.
REQ-024 Simultaneous requests SHALL be served in round-robin order; no requester is granted twice while another is continuously pending.
REQ-025 char_valid, char_last and ack SHALL be 0 outside SEND/DONE as applicable; grant_id holds its last value in IDLE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, char_valid=0, char_last=0, char_data=8'h20, ack=0, busy=0, grant_id=0, rr_ptr=0, and clear the BCD register.
REQ-027 Reset during CONV or SEND SHALL abandon the operation without issuing ack.

Configuration
REQ-028 Macro LEADING_BLANK_EN defined: digit positions above the most significant nonzero digit SHALL emit 8'h20 (space); the index-0 digit SHALL always emit '0'..'9'.
REQ-029 Macro LEADING_BLANK_EN undefined: all DIGITS positions SHALL emit 8'h30 + nibble, including leading zeros.
REQ-030 Character count, timing and handshake SHALL be identical in both builds.

Verification (WIDTH=8, DIGITS=3, NREQ=2, char_ready=1 unless stated)
REQ-031 req[0]=1, value0=255 -> "2","5","5" (0x32,0x35,0x35); char_last on the third character; ack[0] pulse 12 cycles after grant.
REQ-032 req[1]=1, value1=7 -> blank build: 0x20,0x20,0x37; non-blank build: 0x30,0x30,0x37. value1=0 -> blank build: 0x20,0x20,0x30.
REQ-033 req=2'b11 after reset (value0=1, value1=2) -> "1" stream with ack[0] first, then "2" stream with ack[1]; grant_id 0 then 1.
REQ-034 value0=120, char_ready=0 for 5 cycles during the second character -> char_data holds 0x32 with char_valid high; output resumes as 0x32, 0x30; no characters lost or duplicated.
REQ-035 rst pulsed during SEND after one transfer -> char_valid=0 and busy=0 immediately; no ack; next request served from the first digit.
